// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Data-memory request/acknowledge bus between the MEM-stage controller and the
// external data memory.
//   dmem_req   : bus request, held until dmem_ack
//   dmem_we    : write strobe (1 = write)
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : write data
//   dmem_be    : byte-lane enables
//   dmem_ack   : single-cycle completion pulse from memory
//   dmem_rdata : read data, valid with dmem_ack
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
   parameter int unsigned BITS = 32
) ();
   logic            dmem_req;
   logic            dmem_we;
   logic [BITS-1:0] dmem_addr;
   logic [BITS-1:0] dmem_wdata;
   logic [3:0]      dmem_be;
   logic            dmem_ack;
   logic [BITS-1:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output dmem_be,
      input  dmem_ack,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_be,
      output dmem_ack,
      output dmem_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Stage-4 (MEM) memory-access controller. Issues one data-memory bus access per
// EX/MEM instruction, stalls stages 1-4 until it completes, tracks the LL/SC
// reservation and returns load data or the SC result toward stage 5.
//
// Ports:
//   clk, rst_          : clock, asynchronous active-low reset
//   alu_out_s4         : effective byte address
//   sel_mem_s4         : memory operation present in stage 4
//   mem_rw_s4          : 1 = read, 0 = write
//   r2_data_s4         : store data
//   byte_en_s4         : byte-lane enables
//   load_link_s4       : LL qualifier (with a read)
//   check_link_s4      : SC qualifier (with a write)
//   halt_s4, link_clr  : kill the reservation
//   dmem               : data-memory bus (master modport)
//   mem_stall          : freeze stages 1-4
//   mem_data_s4        : load data / SC result
//   link_valid         : reservation held
//   bus_err            : sticky access-timeout flag
//
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses that see no
// dmem_ack within TIMEOUT_CYCLES BUSY cycles (sets bus_err, returns DEADBEEF).
// Without it BUSY waits indefinitely and bus_err is tied low.
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int unsigned BITS           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [BITS-1:0]     alu_out_s4,
   input  logic                sel_mem_s4,
   input  logic                mem_rw_s4,
   input  logic [BITS-1:0]     r2_data_s4,
   input  logic [3:0]          byte_en_s4,
   input  logic                load_link_s4,
   input  logic                check_link_s4,
   input  logic                halt_s4,
   input  logic                link_clr,
   dmem_access_ctrl_if.master  dmem,
   output logic                mem_stall,
   output logic [BITS-1:0]     mem_data_s4,
   output logic                link_valid,
   output logic                bus_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [BITS-1:0]   addr_q, addr_d;
   logic [BITS-1:0]   wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [BITS-1:0]   data_q, data_d;
   logic              link_valid_q, link_valid_d;
   logic [BITS-3:0]   link_addr_q, link_addr_d;
   logic              is_rd_q, is_rd_d;
   logic              is_ll_q, is_ll_d;
   logic              is_sc_q, is_sc_d;

   logic              sc_req, sc_ok;
   logic              link_set, link_kill;
   logic              tmo_hit;
   logic [BITS-1:0]   lane_mask;

   assign sc_req = check_link_s4 && !mem_rw_s4;
   assign sc_ok  = link_valid_q && (link_addr_q == alu_out_s4[BITS-1:2]);

   assign mem_stall = ((state_q == StIdle) && sel_mem_s4) || (state_q == StBusy);

   // Zero the read-data lanes that were not enabled.
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < 4; i++) begin
         lane_mask[i*8 +: 8] = {8{be_q[i]}};
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      data_d       = data_q;
      is_rd_d      = is_rd_q;
      is_ll_d      = is_ll_q;
      is_sc_d      = is_sc_q;
      link_addr_d  = link_addr_q;
      link_valid_d = link_valid_q;
      link_set     = 1'b0;
      link_kill    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sel_mem_s4) begin
               if (sc_req && !sc_ok) begin
                  // Lost reservation: no bus cycle, report failure.
                  data_d    = '0;
                  link_kill = 1'b1;
                  state_d   = StDone;
               end else begin
                  req_d   = 1'b1;
                  we_d    = ~mem_rw_s4;
                  addr_d  = alu_out_s4 & ~(BITS'(3));
                  wdata_d = r2_data_s4;
                  be_d    = byte_en_s4;
                  is_rd_d = mem_rw_s4;
                  is_ll_d = mem_rw_s4 && load_link_s4;
                  is_sc_d = sc_req;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (dmem.dmem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = StDone;
               if (is_rd_q) begin
                  data_d   = dmem.dmem_rdata & lane_mask;
                  link_set = is_ll_q;
               end else if (is_sc_q) begin
                  data_d    = BITS'(1);
                  link_kill = 1'b1;
               end else begin
                  data_d    = '0;
                  link_kill = (addr_q[BITS-1:2] == link_addr_q);
               end
            end else if (tmo_hit) begin
               // Abandoned access: leave the reservation untouched.
               req_d   = 1'b0;
               we_d    = 1'b0;
               data_d  = BITS'(32'hDEAD_BEEF);
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (link_set) begin
         link_valid_d = 1'b1;
         link_addr_d  = addr_q[BITS-1:2];
      end
      // External kills win over an LL completing in the same cycle.
      if (link_kill || link_clr || halt_s4) begin
         link_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= StIdle;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= 4'hF;
         data_q       <= '0;
         is_rd_q      <= 1'b0;
         is_ll_q      <= 1'b0;
         is_sc_q      <= 1'b0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         data_q       <= data_d;
         is_rd_q      <= is_rd_d;
         is_ll_q      <= is_ll_d;
         is_sc_q      <= is_sc_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            bus_err_q, bus_err_d;

   // Fires in the TIMEOUT_CYCLES-th BUSY cycle if that cycle also lacks an ack.
   assign tmo_hit = (state_q == StBusy) && !dmem.dmem_ack &&
                    (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if ((state_q == StBusy) && !dmem.dmem_ack) begin
         tmo_cnt_d = tmo_cnt_q + CntW'(1);
      end
      bus_err_d = bus_err_q | tmo_hit;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         tmo_cnt_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;
`else
   assign tmo_hit = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;
   assign mem_data_s4     = data_q;
   assign link_valid      = link_valid_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Scoreboard bench: the driver computes each instruction's expected result from
// the LL/SC and bus rules and queues it; a memory responder answers bus
// requests and checks the bus fields; a completion monitor compares the MEM/WB
// result, reservation state and stall length whenever an instruction retires.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

   localparam int TMO   = 8;
   localparam int KRead = 0;
   localparam int KLl   = 1;
   localparam int KWr   = 2;
   localparam int KSc   = 3;

   typedef struct {
      logic [31:0] data;
      logic        link;
      logic        berr;
      int          stall;
   } exp_t;

   typedef struct {
      int          delay;   // BUSY cycle of the ack; 0 = never ack
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
      int          kill;    // 1 = link_clr, 2 = halt_s4 during the ack cycle
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_;
   logic [31:0] alu_out_s4, r2_data_s4, mem_data_s4;
   logic        sel_mem_s4, mem_rw_s4, load_link_s4, check_link_s4;
   logic        halt_s4, link_clr;
   logic [3:0]  byte_en_s4;
   logic        mem_stall, link_valid, bus_err;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   rsp_t rsp_q[$];

   // Reference reservation state
   logic        m_link;
   logic [29:0] m_word;
   logic        m_berr;

   dmem_access_ctrl_if #(.BITS(32)) bus ();

   dmem_access_ctrl #(
      .BITS           (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst_          (rst_),
      .alu_out_s4    (alu_out_s4),
      .sel_mem_s4    (sel_mem_s4),
      .mem_rw_s4     (mem_rw_s4),
      .r2_data_s4    (r2_data_s4),
      .byte_en_s4    (byte_en_s4),
      .load_link_s4  (load_link_s4),
      .check_link_s4 (check_link_s4),
      .halt_s4       (halt_s4),
      .link_clr      (link_clr),
      .dmem          (bus),
      .mem_stall     (mem_stall),
      .mem_data_s4   (mem_data_s4),
      .link_valid    (link_valid),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] be);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) m[i*8 +: 8] = d[i*8 +: 8];
      end
      return m;
   endfunction

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Issue one instruction; caller is just after a rising edge.
   task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int delay, input logic [31:0] rdata,
                        input int kill);
      exp_t        e;
      rsp_t        r;
      logic        has_bus;
      logic [29:0] w;
      int          n;
      w = addr[31:2];
      if (kind == KSc && !(m_link && w == m_word)) begin
         has_bus = 1'b0;
         e.data  = 32'h0;
         e.stall = 1;
         m_link  = 1'b0;
      end else begin
         has_bus = 1'b1;
         if (delay == 0) begin
            e.data  = 32'hDEAD_BEEF;
            e.stall = TMO + 1;
            m_berr  = 1'b1;
         end else begin
            e.stall = delay + 1;
            case (kind)
               KRead: e.data = lanes(rdata, be);
               KLl: begin
                  e.data = lanes(rdata, be);
                  m_link = 1'b1;
                  m_word = w;
               end
               KWr: begin
                  e.data = 32'h0;
                  if (w == m_word) m_link = 1'b0;
               end
               default: begin
                  e.data = 32'h1;
                  m_link = 1'b0;
               end
            endcase
            if (kill != 0) m_link = 1'b0;
         end
      end
      e.link = m_link;
      e.berr = m_berr;
      if (has_bus) begin
         r.delay = delay;
         r.rdata = rdata;
         r.addr  = {addr[31:2], 2'b00};
         r.wdata = data;
         r.we    = (kind == KWr || kind == KSc);
         r.be    = be;
         r.kill  = kill;
         rsp_q.push_back(r);
      end
      exp_q.push_back(e);

      alu_out_s4    = addr;
      r2_data_s4    = data;
      byte_en_s4    = be;
      mem_rw_s4     = (kind == KRead || kind == KLl);
      load_link_s4  = (kind == KLl);
      check_link_s4 = (kind == KSc);
      sel_mem_s4    = 1'b1;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_stall && n < 400);
      if (mem_stall) begin
         errors++;
         checks++;
         $display("FAIL completion_timeout: got stall after %0d cycles want release", n);
         finish_run();
      end
      @(posedge clk);
      #1;
      sel_mem_s4    = 1'b0;
      load_link_s4  = 1'b0;
      check_link_s4 = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Memory responder: answers requests and checks the bus fields at ack time.
   initial begin
      rsp_t r;
      int   n;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = '0;
      link_clr       = 1'b0;
      halt_s4        = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_ === 1'b1 && bus.dmem_req === 1'b1) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_req", 32'(bus.dmem_req), 32'h0);
               n = 0;
               while (bus.dmem_req === 1'b1 && n < 1000) begin
                  @(negedge clk);
                  n++;
               end
            end else begin
               r = rsp_q.pop_front();
               if (r.delay == 0) begin
                  n = 0;
                  while (bus.dmem_req === 1'b1 && n < 1000) begin
                     @(negedge clk);
                     n++;
                  end
               end else begin
                  repeat (r.delay - 1) @(negedge clk);
                  chk("bus_req", 32'(bus.dmem_req), 32'h1);
                  chk("bus_addr", bus.dmem_addr, r.addr);
                  chk("bus_we", 32'(bus.dmem_we), 32'(r.we));
                  chk("bus_be", 32'(bus.dmem_be), 32'(r.be));
                  if (r.we) chk("bus_wdata", bus.dmem_wdata, r.wdata);
                  #1;
                  bus.dmem_ack   = 1'b1;
                  bus.dmem_rdata = r.rdata;
                  link_clr       = (r.kill == 1);
                  halt_s4        = (r.kill == 2);
                  @(posedge clk);
                  #1;
                  bus.dmem_ack   = 1'b0;
                  bus.dmem_rdata = $urandom();
                  link_clr       = 1'b0;
                  halt_s4        = 1'b0;
               end
            end
         end
      end
   end

   // Completion monitor: an instruction retires in the cycle it is present
   // without a stall.
   initial begin
      exp_t e;
      int   stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst_ !== 1'b1 || sel_mem_s4 !== 1'b1) begin
            stall_cnt = 0;
         end else if (mem_stall === 1'b1) begin
            stall_cnt++;
         end else begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(exp_q.size()), 32'h1);
            end else begin
               e = exp_q.pop_front();
               chk("mem_data_s4", mem_data_s4, e.data);
               chk("link_valid", 32'(link_valid), 32'(e.link));
               chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
               chk("bus_err", 32'(bus_err), 32'(e.berr));
               chk("done_req_low", 32'(bus.dmem_req), 32'h0);
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   // Driver
   initial begin
      logic [31:0] words [4];
      int          kind, kill, n;
      rsp_t        r;
      words = '{32'h40, 32'h44, 32'h80, 32'h100};
      m_link = 1'b0;
      m_word = '0;
      m_berr = 1'b0;
      rst_          = 1'b0;
      sel_mem_s4    = 1'b0;
      mem_rw_s4     = 1'b1;
      load_link_s4  = 1'b0;
      check_link_s4 = 1'b0;
      alu_out_s4    = '0;
      r2_data_s4    = '0;
      byte_en_s4    = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(bus.dmem_req), 32'h0);
      chk("rst_we", 32'(bus.dmem_we), 32'h0);
      chk("rst_addr", bus.dmem_addr, 32'h0);
      chk("rst_wdata", bus.dmem_wdata, 32'h0);
      chk("rst_be", 32'(bus.dmem_be), 32'hF);
      chk("rst_data", mem_data_s4, 32'h0);
      chk("rst_link", 32'(link_valid), 32'h0);
      chk("rst_berr", 32'(bus_err), 32'h0);
      chk("rst_stall", 32'(mem_stall), 32'h0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      do_op(KRead, 32'h0000_0104, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
      do_op(KWr, 32'h0000_0203, 32'hAABB_CCDD, 4'b0011, 1, 32'h0, 0);
      do_op(KLl, 32'h40, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 0);
      do_op(KSc, 32'h40, 32'h5, 4'hF, 1, 32'h0, 0);
      do_op(KLl, 32'h40, 32'h0, 4'hF, 1, 32'h0BAD_0001, 0);
      do_op(KWr, 32'h40, 32'h77, 4'hF, 2, 32'h0, 0);
      do_op(KSc, 32'h40, 32'h5, 4'hF, 1, 32'h0, 0);
      do_op(KLl, 32'h80, 32'h0, 4'hF, 2, 32'h8080_8080, 1);
      do_op(KWr, 32'h44, 32'h1, 4'h0, 1, 32'h0, 0);
      do_op(KRead, 32'h100, 32'h0, 4'b1010, 4, 32'hFFEE_DDCC, 0);

      // Reset during BUSY abandons the access at once.
      r.delay = 0;
      r.rdata = '0;
      r.addr  = 32'h300;
      r.wdata = '0;
      r.we    = 1'b0;
      r.be    = 4'hF;
      r.kill  = 0;
      rsp_q.push_back(r);
      alu_out_s4 = 32'h300;
      mem_rw_s4  = 1'b1;
      sel_mem_s4 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.dmem_req !== 1'b1 && n < 20);
      chk("busy_req_before_rst", 32'(bus.dmem_req), 32'h1);
      #2;
      rst_       = 1'b0;
      sel_mem_s4 = 1'b0;
      #1;
      chk("midrst_req", 32'(bus.dmem_req), 32'h0);
      chk("midrst_stall", 32'(mem_stall), 32'h0);
      chk("midrst_be", 32'(bus.dmem_be), 32'hF);
      chk("midrst_link", 32'(link_valid), 32'h0);
      @(posedge clk);
      #1;
      rst_   = 1'b1;
      m_link = 1'b0;
      m_word = '0;
      m_berr = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 3);
         kill = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
         do_op(kind, words[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom(),
               4'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom(), kill);
      end

`ifdef DMEM_TIMEOUT_EN
      do_op(KLl, 32'h40, 32'h0, 4'hF, 2, 32'h1111_2222, 0);
      do_op(KLl, 32'h100, 32'h0, 4'hF, 0, 32'h0, 0);
      do_op(KRead, 32'h80, 32'h0, 4'hF, 1, 32'h3333_4444, 0);
      do_op(KSc, 32'h40, 32'h9, 4'hF, 1, 32'h0, 0);
`endif

      repeat (4) @(posedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
      chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
      finish_run();
   end

endmodule
